mem_sync: RTL and testbench

MEM_SYNC -- requirements
Module: mem_sync

---
 rtl/mem_sync.sv | 123 ++++++++++++
 tb/tb_mem_sync.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync.sv
// Single-port synchronous word memory with a hardware zeroing sweep after reset or clear.
// Requests are accepted only in IDLE; read data is registered with one cycle of latency.
`timescale 1ns/1ps

module mem_sync #(
    parameter int WORDSIZE   = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Enable,
    input  logic                  WE,
    input  logic                  RE,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WORDSIZE-1:0]   data_in,
    output logic [WORDSIZE-1:0]   data_out,
    output logic                  rd_valid,
    output logic                  ready,
    output logic                  err
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1'b1);

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [WORDSIZE-1:0]   data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;

    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [WORDSIZE-1:0]   mem_wdata_s;
    logic [WORDSIZE-1:0]   mem_q [NUM_WORDS];

    // Next-state, memory write port and output pulse computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        err_d       = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = address;
        mem_wdata_s = data_in;

        case (state_q)
            INIT: begin
                // Sweep one word per cycle; clr and requests are ignored here.
                mem_we_s    = ~rst;
                mem_addr_s  = cnt_q;
                mem_wdata_s = '0;
                cnt_d       = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = INIT;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (Enable && WE && !RE) begin
                    mem_we_s = ~rst;
                end else if (Enable && RE && !WE) begin
                    data_out_d = mem_q[address];
                    rd_valid_d = 1'b1;
                end else if (Enable && WE && RE) begin
                    err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    // Storage array; contents are defined only by the sweep and accepted writes.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign ready    = ready_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_sync.sv
// Directed and table-driven checks of mem_sync, plus random traffic on three widths against array models.
`timescale 1ns/1ps

module tb_mem_sync;

    logic        clk = 1'b0;
    logic        rst, en, we, re, clr;
    logic [8:0]  addr;
    logic [31:0] din;

    logic        dout_s, vld_s, rdy_s, err_s;
    logic [7:0]  dout_m;
    logic        vld_m, rdy_m, err_m;
    logic [31:0] dout_l;
    logic        vld_l, rdy_l, err_l;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_sync #(.WORDSIZE(8), .ADDR_WIDTH(4)) dut_m (
        .clk(clk), .rst(rst), .Enable(en), .WE(we), .RE(re), .clr(clr),
        .address(addr[3:0]), .data_in(din[7:0]),
        .data_out(dout_m), .rd_valid(vld_m), .ready(rdy_m), .err(err_m)
    );

    mem_sync #(.WORDSIZE(1), .ADDR_WIDTH(1)) dut_s (
        .clk(clk), .rst(rst), .Enable(en), .WE(we), .RE(re), .clr(clr),
        .address(addr[0:0]), .data_in(din[0:0]),
        .data_out(dout_s), .rd_valid(vld_s), .ready(rdy_s), .err(err_s)
    );

    mem_sync #(.WORDSIZE(32), .ADDR_WIDTH(9)) dut_l (
        .clk(clk), .rst(rst), .Enable(en), .WE(we), .RE(re), .clr(clr),
        .address(addr), .data_in(din),
        .data_out(dout_l), .rd_valid(vld_l), .ready(rdy_l), .err(err_l)
    );

    typedef struct {
        logic       en, we, re, clr;
        logic [3:0] addr;
        logic [7:0] din;
        logic [7:0] dout;
        logic       vld, err, rdy;
    } vec_t;

    vec_t vecs [14];

    logic        model_s [2];
    logic [7:0]  model_m [16];
    logic [31:0] model_l [512];
    logic        exp_s;
    logic [7:0]  exp_m;
    logic [31:0] exp_l;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic w, input logic r, input logic c,
                         input logic [8:0] a, input logic [31:0] d);
        en = e; we = w; re = r; clr = c; addr = a; din = d;
    endtask

    // Counts samples with ready low, starting from the current sample.
    task automatic wait_ready(output int low);
        low = 0;
        for (int i = 0; i < 100 && !rdy_m; i++) begin
            low++;
            tick();
        end
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        drive(1'b1, 1'b0, 1'b1, 1'b0, {5'd0, a}, 32'd0);
        tick();
        chk({name, " dout"}, 32'(dout_m), 32'(exp));
        chk({name, " vld"}, 32'(vld_m), 32'd1);
    endtask

    initial begin
        int low;
        // en we re clr addr din | dout vld err rdy
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  8'hA5, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  8'hFF, 8'hA5, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  8'h77, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5,  8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  8'h11, 8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  8'h00, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 8'h11, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b1, 1'b0, 1'b1};

        // Reset and initial sweep length.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst ready", 32'(rdy_m), 32'd0);
        chk("rst vld", 32'(vld_m), 32'd0);
        chk("rst err", 32'(err_m), 32'd0);
        chk("rst dout", 32'(dout_m), 32'd0);
        wait_ready(low);
        chk("init low cycles", 32'(low), 32'd16);

        for (int a = 0; a < 16; a++) begin
            rd_chk($sformatf("zero%0d", a), 4'(a), 8'h00);
        end

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].re, vecs[i].clr, {5'd0, vecs[i].addr}, {24'd0, vecs[i].din});
            tick();
            chk($sformatf("vec%0d dout", i), 32'(dout_m), 32'(vecs[i].dout));
            chk($sformatf("vec%0d vld", i), 32'(vld_m), 32'(vecs[i].vld));
            chk($sformatf("vec%0d err", i), 32'(err_m), 32'(vecs[i].err));
            chk($sformatf("vec%0d rdy", i), 32'(rdy_m), 32'(vecs[i].rdy));
        end

        // Clear colliding with a write; clr held into INIT must not restart the sweep.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 9'd7, 32'h3C);
        tick();
        chk("clr ready", 32'(rdy_m), 32'd0);
        chk("clr err", 32'(err_m), 32'd0);
        low = 0;
        for (int i = 0; i < 100 && !rdy_m; i++) begin
            low++;
            if (i == 4) drive(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
            tick();
        end
        chk("clr low cycles", 32'(low), 32'd16);
        chk("clr dout held", 32'(dout_m), 32'hA5);
        rd_chk("clr a7", 4'd7, 8'h00);
        rd_chk("clr a3", 4'd3, 8'h00);

        // Reset mid-sweep, with requests during INIT.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 9'd9, 32'hC3);
        tick();
        rd_chk("pre rst a9", 4'd9, 8'hC3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2 dout", 32'(dout_m), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i[0], 1'b1, 1'b0, 9'd3, 32'd0);
            tick();
            chk($sformatf("init%0d vld", i), 32'(vld_m), 32'd0);
            chk($sformatf("init%0d err", i), 32'(err_m), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 9'd3, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst3 vld", 32'(vld_m), 32'd0);
        wait_ready(low);
        chk("rst mid low cycles", 32'(low), 32'd16);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        chk("rst mid dout", 32'(dout_m), 32'd0);
        rd_chk("post rst a9", 4'd9, 8'h00);

        // Random traffic on all three widths.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 700 && !(rdy_s && rdy_m && rdy_l); i++) tick();
        chk("rnd ready", 32'({rdy_s, rdy_m, rdy_l}), 32'd7);
        for (int a = 0; a < 512; a++) model_l[a] = 32'd0;
        for (int a = 0; a < 16; a++) model_m[a] = 8'd0;
        model_s[0] = 1'b0;
        model_s[1] = 1'b0;
        exp_s = 1'b0;
        exp_m = 8'd0;
        exp_l = 32'd0;
        for (int i = 0; i < 400; i++) begin
            logic e, w, r;
            e = ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            drive(e, w, r, 1'b0,
                  ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511)),
                  $urandom());
            if (e && w && !r) begin
                model_s[addr[0]]   = din[0];
                model_m[addr[3:0]] = din[7:0];
                model_l[addr]      = din;
            end else if (e && r && !w) begin
                exp_s = model_s[addr[0]];
                exp_m = model_m[addr[3:0]];
                exp_l = model_l[addr];
            end
            tick();
            chk($sformatf("rnd%0d dout_s", i), 32'(dout_s), 32'(exp_s));
            chk($sformatf("rnd%0d dout_m", i), 32'(dout_m), 32'(exp_m));
            chk($sformatf("rnd%0d dout_l", i), dout_l, exp_l);
            chk($sformatf("rnd%0d vld", i), 32'({vld_s, vld_m, vld_l}), (e && r && !w) ? 32'd7 : 32'd0);
            chk($sformatf("rnd%0d err", i), 32'({err_s, err_m, err_l}), (e && r && w) ? 32'd7 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
